// File: rtl/seq_binary_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Start/done handshake, saturating overflow and leading-zero blanking flags.
module seq_binary_to_bcd #(
    parameter int unsigned WIDTH  = 13,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      number,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} ^ DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [SW-1:0]     scratch_q, scratch_d;
    logic              ovf_q, ovf_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     digits_q, digits_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [SW-1:0]     adj;
    logic              hi_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs; DONE holds the last sticky overflow before publishing.
    always_comb begin
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        digits_d   = digits_q;
        blank_d    = blank_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        busy_d     = (state_d != IDLE) || (state_q == DONE);
        adj        = scratch_q;
        hi_zero    = 1'b1;

        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = number;
                    scratch_d = '0;
                    ovf_d     = 1'b0;
                    cnt_d     = CW'(WIDTH - 1);
                end
            end
            SHIFT: begin
                scratch_d = {adj[SW-2:0], shift_q[WIDTH-1]};
                shift_d   = shift_q << 1;
                ovf_d     = ovf_q | adj[SW-1];
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                digits_d   = ovf_q ? {DIGITS{4'd9}} : scratch_q;
                overflow_d = ovf_q;
                done_d     = 1'b1;
                for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
                    hi_zero    = hi_zero & (digits_d[4*i +: 4] == 4'd0);
                    blank_d[i] = hi_zero;
                end
                blank_d[0] = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            scratch_q  <= '0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            digits_q   <= '0;
            blank_q    <= BLANK_RST;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
            blank_q    <= blank_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign digits   = digits_q;
    assign blank    = blank_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// Bench for seq_binary_to_bcd: a 4-digit and a 3-digit instance checked every cycle
// against a decimal arithmetic model, plus literal pins on key conversions.
module tb_seq_binary_to_bcd;

    localparam int W = 13;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic [12:0] number_a, number_b;
    logic        busy_a, done_a, ovf_a;
    logic [15:0] digits_a;
    logic [3:0]  blank_a;
    logic        busy_b, done_b, ovf_b;
    logic [11:0] digits_b;
    logic [2:0]  blank_b;

    always #5 clk = ~clk;

    seq_binary_to_bcd #(.WIDTH(13), .DIGITS(4)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .number(number_a),
        .busy(busy_a), .done(done_a), .digits(digits_a), .blank(blank_a), .overflow(ovf_a)
    );

    seq_binary_to_bcd #(.WIDTH(13), .DIGITS(3)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .number(number_b),
        .busy(busy_b), .done(done_b), .digits(digits_b), .blank(blank_b), .overflow(ovf_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Decimal reference conversion using plain division.
    function automatic void conv(input int unsigned v, input int d,
                                 output logic [39:0] dg, output logic [9:0] bk, output logic ov);
        longint unsigned lim;
        longint unsigned p;
        int unsigned r;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        dg = '0;
        bk = '0;
        ov = (longint'(v) >= lim);
        r  = v;
        if (ov) begin
            for (int i = 0; i < d; i++) dg[4*i +: 4] = 4'd9;
        end else begin
            for (int i = 0; i < d; i++) begin
                dg[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
            p = 10;
            for (int i = 1; i < d; i++) begin
                bk[i] = (longint'(v) < p);
                p = p * 10;
            end
        end
    endfunction

    int          m_age [2];
    int unsigned m_num [2];
    logic        e_busy[2], e_done[2], e_ovf[2];
    logic [39:0] e_dig [2];
    logic [9:0]  e_blk [2];

    // Transaction-level timing model: age counts edges since acceptance.
    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            logic        st;
            int unsigned nm;
            int          d;
            st = (j == 0) ? start_a : start_b;
            nm = (j == 0) ? int'(number_a) : int'(number_b);
            d  = (j == 0) ? 4 : 3;
            if (reset) begin
                m_age[j]  = -1;
                e_busy[j] = 1'b0;
                e_done[j] = 1'b0;
                e_ovf[j]  = 1'b0;
                e_dig[j]  = '0;
                e_blk[j]  = 10'((1 << d) - 2);
            end else begin
                if (m_age[j] >= 0) m_age[j]++;
                if (m_age[j] == W + 2) m_age[j] = -1;
                e_done[j] = (m_age[j] == W + 1);
                if (e_done[j]) conv(m_num[j], d, e_dig[j], e_blk[j], e_ovf[j]);
                if (m_age[j] == -1 && st) begin
                    m_age[j] = 0;
                    m_num[j] = nm;
                end
                e_busy[j] = (m_age[j] >= 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [52:0] g, x;
            g = {busy_a, done_a, ovf_a, 10'(blank_a), 40'(digits_a)};
            x = {e_busy[0], e_done[0], e_ovf[0], e_blk[0], e_dig[0]};
            n_cmp++;
            if (g !== x) begin
                n_err++;
                if (n_err < 40)
                    $display("FAIL model_a cyc=%0d: got busy=%b done=%b ovf=%b blank=%b digits=%h, expected busy=%b done=%b ovf=%b blank=%b digits=%h",
                             cyc, busy_a, done_a, ovf_a, blank_a, digits_a,
                             e_busy[0], e_done[0], e_ovf[0], e_blk[0][3:0], e_dig[0][15:0]);
            end
            g = {busy_b, done_b, ovf_b, 10'(blank_b), 40'(digits_b)};
            x = {e_busy[1], e_done[1], e_ovf[1], e_blk[1], e_dig[1]};
            n_cmp++;
            if (g !== x) begin
                n_err++;
                if (n_err < 40)
                    $display("FAIL model_b cyc=%0d: got busy=%b done=%b ovf=%b blank=%b digits=%h, expected busy=%b done=%b ovf=%b blank=%b digits=%h",
                             cyc, busy_b, done_b, ovf_b, blank_b, digits_b,
                             e_busy[1], e_done[1], e_ovf[1], e_blk[1][2:0], e_dig[1][11:0]);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_done(input int which, output int t);
        bit seen;
        seen = 1'b0;
        t    = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if ((which == 0) ? done_a : done_b) begin
                seen = 1'b1;
                t    = cyc;
            end
        end
        check("done_timeout", 64'(seen), 64'(1));
    endtask

    task automatic conv_a(input int unsigned v, input logic [15:0] xd, input logic [3:0] xb, input logic xo);
        int t0, t1;
        @(negedge clk);
        start_a  = 1'b1;
        number_a = 13'(v);
        @(negedge clk);
        start_a  = 1'b0;
        number_a = 13'($urandom);
        t0 = cyc;
        wait_done(0, t1);
        check("latency_a", 64'(t1 - t0), 64'(14));
        check("digits_a", 64'(digits_a), 64'(xd));
        check("blank_a", 64'(blank_a), 64'(xb));
        check("ovf_a", 64'(ovf_a), 64'(xo));
    endtask

    task automatic conv_b(input int unsigned v, input logic [11:0] xd, input logic [2:0] xb, input logic xo);
        int t0, t1;
        @(negedge clk);
        start_b  = 1'b1;
        number_b = 13'(v);
        @(negedge clk);
        start_b  = 1'b0;
        number_b = 13'($urandom);
        t0 = cyc;
        wait_done(1, t1);
        check("latency_b", 64'(t1 - t0), 64'(14));
        check("digits_b", 64'(digits_b), 64'(xd));
        check("blank_b", 64'(blank_b), 64'(xb));
        check("ovf_b", 64'(ovf_b), 64'(xo));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, 64'(digits_a), 64'(0));
        check({tag, "_blank"}, 64'(blank_a), 64'(4'b1110));
        check({tag, "_ovf"}, 64'(ovf_a), 64'(0));
        check({tag, "_busy"}, 64'(busy_a), 64'(0));
        check({tag, "_done"}, 64'(done_a), 64'(0));
    endtask

    initial begin
        int t1, t2, tprev;
        bit any_done;
        int unsigned vals[$];

        reset    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        number_a = '0;
        number_b = '0;
        @(posedge clk);
        #1 chk_en = 1'b1;

        // start together with reset must not begin a conversion
        @(negedge clk);
        start_a  = 1'b1;
        start_b  = 1'b1;
        number_a = 13'd123;
        @(negedge clk);
        check_reset_outputs("rst");
        check("rst_blank_b", 64'(blank_b), 64'(3'b110));
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        check("idle_after_rst_start", 64'(busy_a), 64'(0));

        conv_a(8191, 16'h8191, 4'b0000, 1'b0);
        conv_a(0,    16'h0000, 4'b1110, 1'b0);
        conv_a(7,    16'h0007, 4'b1110, 1'b0);
        conv_b(1000, 12'h999,  3'b000,  1'b1);
        conv_b(999,  12'h999,  3'b000,  1'b0);

        // start held while busy: single result, next accepted after full period
        @(negedge clk);
        start_a  = 1'b1;
        number_a = 13'd42;
        @(negedge clk);
        number_a = 13'd77;
        wait_done(0, t1);
        check("held_first", 64'(digits_a), 64'(16'h0042));
        wait_done(0, t2);
        start_a = 1'b0;
        check("held_period", 64'(t2 - t1), 64'(15));
        check("held_second", 64'(digits_a), 64'(16'h0077));

        // abort mid conversion
        repeat (3) @(negedge clk);
        start_a  = 1'b1;
        number_a = 13'd500;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("abort");
        any_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            any_done = any_done | done_a;
        end
        check("abort_no_done", 64'(any_done), 64'(0));
        conv_a(305, 16'h0305, 4'b1000, 1'b0);

        // random traffic on both instances, with occasional reset
        repeat (3000) begin
            @(negedge clk);
            start_a  = ($urandom % 4 == 0);
            number_a = 13'($urandom);
            start_b  = ($urandom % 3 == 0);
            number_b = ($urandom % 2 == 1) ? 13'(990 + $urandom % 30) : 13'($urandom);
            reset    = ($urandom % 400 == 0);
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        reset   = 1'b0;
        repeat (40) @(negedge clk);

        // back-to-back sweep with start held
        for (int v = 0; v < 1000; v++) vals.push_back(v);
        for (int v = 1000; v < 8100; v += 7) vals.push_back(v);
        for (int v = 8100; v <= 8191; v++) vals.push_back(v);
        @(negedge clk);
        start_a  = 1'b1;
        number_a = 13'(vals[0]);
        tprev    = 0;
        for (int k = 0; k < vals.size(); k++) begin
            wait_done(0, t1);
            if (k > 0) check("sweep_period", 64'(t1 - tprev), 64'(15));
            tprev = t1;
            if (k + 1 < vals.size()) number_a = 13'(vals[k + 1]);
            else start_a = 1'b0;
        end
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
